// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared types and default parameters
// for the interrupt controller slice.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } irq_state_t;

  localparam logic [15:0] DEF_IE_ADDR    = 16'hFFFF;
  localparam logic [15:0] DEF_IF_ADDR    = 16'hFF0F;
  localparam logic [15:0] DEF_VEC_BASE   = 16'h0040;
  localparam int          DEF_VEC_STRIDE = 8;

  function automatic logic [15:0] irq_vec(
    input logic [15:0] base,
    input int          stride,
    input logic [2:0]  id
  );
    return base + 16'(stride) * {13'd0, id};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder,
// lowest set index wins.
module irq_prio_enc #(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [2:0]         id,
  output logic               valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    // scan downward so the lowest set bit is the last one kept
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped IE/IF registers, priority
// arbitration and a REQ/ACK handshake toward the CPU.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ    = 5,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
  parameter logic [15:0]        IE_ADDR    = DEF_IE_ADDR,
  parameter logic [15:0]        IF_ADDR    = DEF_IF_ADDR,
  parameter logic [15:0]        VEC_BASE   = DEF_VEC_BASE,
  parameter int                 VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  input  logic [NUM_IRQ-1:0] src_req,
  output logic [NUM_IRQ-1:0] src_ack,
  output logic               int_req,
  output logic [15:0]        int_vec,
  output logic [2:0]         int_id,
  input  logic               int_ack,
  output logic               sel
);

  if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_num
    $error("irq_ctrl: NUM_IRQ must be in 1..8");
  end

  irq_state_t         state;
  logic [NUM_IRQ-1:0] ie;
  logic [NUM_IRQ-1:0] iflag;
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] set;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] id_mask;
  logic [NUM_IRQ-1:0] if_nxt;
  logic [NUM_IRQ-1:0] ie_nxt;
  logic [NUM_IRQ-1:0] pend;
  logic               armed;
  logic               ie_hit;
  logic               if_hit;
  logic               keep;
  logic               win_vld;
  logic [2:0]         win_id;
  logic               unused_ok;

  assign ie_hit = (a == IE_ADDR);
  assign if_hit = (a == IF_ADDR);
  assign sel    = ie_hit | if_hit;

  // armed blocks a level held high through reset from
  // looking like a fresh rising edge
  assign set = src_req &
               (~EDGE_MASK | (~src_q & {NUM_IRQ{armed}}));

  assign id_mask = NUM_IRQ'(1) << int_id;
  assign clr     = (state == REQ && int_ack) ? id_mask : '0;
  assign src_ack = rst ? '0 : clr;

  assign if_nxt = ((wr && if_hit) ? din[NUM_IRQ-1:0]
                                  : (iflag & ~clr)) | set;
  assign ie_nxt = (wr && ie_hit) ? din[NUM_IRQ-1:0] : ie;
  assign keep   = |(if_nxt & ie_nxt & id_mask);
  assign pend   = ie & iflag;

  assign int_vec   = irq_vec(VEC_BASE, VEC_STRIDE, int_id);
  assign unused_ok = ^{rd, din};

  always_comb begin
    dout = 8'hFF;
    if (if_hit) begin
      dout[NUM_IRQ-1:0] = iflag | set;
    end else if (ie_hit) begin
      dout              = 8'h00;
      dout[NUM_IRQ-1:0] = ie;
    end
  end

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_enc (
    .req  (pend),
    .id   (win_id),
    .valid(win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ie      <= '0;
      iflag   <= '0;
      src_q   <= '0;
      armed   <= 1'b0;
      state   <= IDLE;
      int_id  <= '0;
      int_req <= 1'b0;
    end else begin
      ie    <= ie_nxt;
      iflag <= if_nxt;
      src_q <= src_req;
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            int_id  <= win_id;
            int_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= ACK;
          end else if (!keep) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: register table, directed handshake
// sequences and a randomized run against a reference model.
module tb_irq_ctrl;

  localparam logic [15:0] IEA = 16'hFFFF;
  localparam logic [15:0] IFA = 16'hFF0F;
  localparam logic [4:0]  EM  = 5'b10101;

  logic        clk = 1'b0;
  logic        rst, rd, wr, int_ack, ack_e;
  logic [15:0] a;
  logic [7:0]  din;
  logic [4:0]  src, src_e;
  logic [7:0]  dout, dout_e;
  logic [4:0]  src_ack, src_ack_e;
  logic        int_req, int_req_e, sel, sel_e;
  logic [15:0] int_vec, int_vec_e;
  logic [2:0]  int_id, int_id_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  din;
    logic [4:0]  src;
    logic [7:0]  dout;
    logic        sel;
  } vec_t;
  vec_t tv[19];

  logic [4:0] em;
  logic [4:0] m_ie, m_if, m_prev;
  bit         m_armed, m_busy, m_gap;
  int         m_id;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout),
    .rd(rd), .wr(wr), .src_req(src), .src_ack(src_ack),
    .int_req(int_req), .int_vec(int_vec), .int_id(int_id),
    .int_ack(int_ack), .sel(sel)
  );

  irq_ctrl #(.EDGE_MASK(EM)) dut_e (
    .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout_e),
    .rd(rd), .wr(wr), .src_req(src_e), .src_ack(src_ack_e),
    .int_req(int_req_e), .int_vec(int_vec_e),
    .int_id(int_id_e), .int_ack(ack_e), .sel(sel_e)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [15:0] ad, input logic [7:0] d);
    a   = ad;
    din = d;
    wr  = 1'b1;
    step();
    wr  = 1'b0;
    a   = 16'h0000;
  endtask

  // Reference: flags, enables and the grant as abstract bookkeeping
  task automatic model_cycle();
    logic [4:0] ev, ackv, nif, nie, p;
    logic [7:0] ed;
    for (int i = 0; i < 5; i++)
      ev[i] = em[i] ? (src_e[i] && !m_prev[i] && m_armed) : src_e[i];
    if (a == IFA)      ed = 8'hE0 | {3'b000, m_if | ev};
    else if (a == IEA) ed = {3'b000, m_ie};
    else               ed = 8'hFF;
    ackv = (!rst && m_busy && ack_e) ? 5'(1 << m_id) : 5'd0;
    chk("r_dout", dout_e, ed);
    chk("r_sel", sel_e, (a == IFA) || (a == IEA));
    chk("r_req", int_req_e, m_busy);
    chk("r_id", int_id_e, m_id);
    chk("r_vec", int_vec_e, 32'h40 + m_id * 8);
    chk("r_ack", src_ack_e, ackv);
    if (rst) begin
      m_ie = 0; m_if = 0; m_prev = 0; m_armed = 0;
      m_busy = 0; m_gap = 0; m_id = 0;
    end else begin
      nif = ((wr && a == IFA) ? din[4:0] : (m_if & ~ackv)) | ev;
      nie = (wr && a == IEA) ? din[4:0] : m_ie;
      if (m_busy) begin
        if (ack_e) begin
          m_busy = 0;
          m_gap  = 1;
        end else if (!(nif[m_id] && nie[m_id])) begin
          m_busy = 0;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else begin
        p = m_ie & m_if;
        if (p != 0) begin
          m_id   = $clog2(int'(p & (~p + 5'd1)));
          m_busy = 1;
        end
      end
      m_if = nif; m_ie = nie; m_prev = src_e; m_armed = 1;
    end
  endtask

  initial begin
    em = EM;
    tv[0]  = '{1'b0, IFA,      8'h00, 5'h00, 8'hE0, 1'b1};
    tv[1]  = '{1'b0, IEA,      8'h00, 5'h00, 8'h00, 1'b1};
    tv[2]  = '{1'b0, 16'h1234, 8'h00, 5'h00, 8'hFF, 1'b0};
    tv[3]  = '{1'b1, IEA,      8'hFF, 5'h00, 8'h00, 1'b1};
    tv[4]  = '{1'b0, IEA,      8'h00, 5'h00, 8'h1F, 1'b1};
    tv[5]  = '{1'b1, 16'h1234, 8'h00, 5'h00, 8'hFF, 1'b0};
    tv[6]  = '{1'b0, IEA,      8'h00, 5'h00, 8'h1F, 1'b1};
    tv[7]  = '{1'b1, IEA,      8'h00, 5'h00, 8'h1F, 1'b1};
    tv[8]  = '{1'b0, IEA,      8'h00, 5'h00, 8'h00, 1'b1};
    tv[9]  = '{1'b1, IFA,      8'h0A, 5'h00, 8'hE0, 1'b1};
    tv[10] = '{1'b0, IFA,      8'h00, 5'h00, 8'hEA, 1'b1};
    tv[11] = '{1'b1, IFA,      8'h00, 5'h00, 8'hEA, 1'b1};
    tv[12] = '{1'b0, IFA,      8'h00, 5'h00, 8'hE0, 1'b1};
    tv[13] = '{1'b0, IFA,      8'h00, 5'h04, 8'hE4, 1'b1};
    tv[14] = '{1'b0, IFA,      8'h00, 5'h00, 8'hE4, 1'b1};
    tv[15] = '{1'b1, IFA,      8'h00, 5'h10, 8'hF4, 1'b1};
    tv[16] = '{1'b0, IFA,      8'h00, 5'h00, 8'hF0, 1'b1};
    tv[17] = '{1'b1, IFA,      8'h00, 5'h00, 8'hF0, 1'b1};
    tv[18] = '{1'b0, IFA,      8'h00, 5'h00, 8'hE0, 1'b1};

    rst = 1; rd = 0; wr = 0; int_ack = 0; ack_e = 0;
    a = 0; din = 0; src = 0; src_e = 0;
    step(); step();
    rst = 0;
    chk("rst_req", int_req, 0);
    chk("rst_id", int_id, 0);
    chk("rst_ack", src_ack, 0);

    foreach (tv[i]) begin
      wr = tv[i].wr; a = tv[i].a; din = tv[i].din;
      src = tv[i].src; rd = !tv[i].wr;
      #1;
      chk($sformatf("tv%0d_dout", i), dout, tv[i].dout);
      chk($sformatf("tv%0d_sel", i), sel, tv[i].sel);
      chk($sformatf("tv%0d_req", i), int_req, 0);
      step();
    end
    wr = 0; src = 0; rd = 0;

    // single pulse, grant and acknowledge
    wr_reg(IEA, 8'h1F);
    src = 5'b00100; step(); src = 0;
    #1 chk("a_lat0", int_req, 0);
    step();
    chk("a_req", int_req, 1);
    chk("a_id", int_id, 2);
    chk("a_vec", int_vec, 16'h0050);
    int_ack = 1;
    #1 chk("a_srcack", src_ack, 5'b00100);
    step(); int_ack = 0;
    a = IFA;
    #1 chk("a_if", dout, 8'hE0);
    chk("a_gap", int_req, 0);

    // two flags at once: priority then the ack gap
    src = 5'b01010; step(); src = 0;
    step();
    chk("b_id1", int_id, 1);
    chk("b_vec1", int_vec, 16'h0048);
    chk("b_req1", int_req, 1);
    int_ack = 1; step(); int_ack = 0;
    chk("b_gap1", int_req, 0);
    step();
    chk("b_gap2", int_req, 0);
    step();
    chk("b_req3", int_req, 1);
    chk("b_id3", int_id, 3);
    chk("b_vec3", int_vec, 16'h0058);

    // higher priority arriving during REQ is deferred
    src = 5'b00001; step(); src = 0;
    chk("c_hold1", int_id, 3);
    step();
    chk("c_hold2", int_id, 3);
    chk("c_holdreq", int_req, 1);
    int_ack = 1;
    #1 chk("c_ack3", src_ack, 5'b01000);
    step(); int_ack = 0;
    step(); step();
    chk("c_req0", int_req, 1);
    chk("c_id0", int_id, 0);
    chk("c_vec0", int_vec, 16'h0040);
    int_ack = 1; step(); int_ack = 0;
    step(); step();
    chk("c_idle", int_req, 0);

    // software withdraws enable, then reset during REQ
    src = 5'b00100; step(); src = 0;
    step();
    chk("d_req", int_req, 1);
    a = IEA; din = 8'h00; wr = 1;
    #1 chk("d_wrack", src_ack, 0);
    step(); wr = 0;
    chk("d_drop", int_req, 0);
    chk("d_noack", src_ack, 0);
    step();
    chk("d_idle", int_req, 0);
    wr_reg(IEA, 8'h1F);
    step();
    chk("d_rearm", int_req, 1);
    chk("d_rearm_id", int_id, 2);
    rst = 1; int_ack = 1;
    #1 chk("d_rstack", src_ack, 0);
    step(); rst = 0; int_ack = 0;
    a = IFA;
    #1 chk("d_rst_req", int_req, 0);
    chk("d_rst_id", int_id, 0);
    chk("d_rst_vec", int_vec, 16'h0040);
    chk("d_rst_if", dout, 8'hE0);

    // edge source held across reset, then held through an ack
    src_e = 5'b00001; rst = 1; step(); rst = 0;
    step(); step();
    a = IFA;
    #1 chk("e_rsthold", dout_e, 8'hE0);
    chk("e_rstreq", int_req_e, 0);
    src_e = 0; step();
    wr_reg(IEA, 8'h1F);
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      src_e[0] = (k < 10);
      ack_e = int_req_e;
      #1 if (src_ack_e[0]) cnt++;
      step();
    end
    ack_e = 0;
    chk("e_once", cnt, 1);
    a = IFA;
    #1 chk("e_if", dout_e, 8'hE0);

    // randomized run on the mixed-mode instance
    rst = 1; src_e = 0; step(); rst = 0;
    m_ie = 0; m_if = 0; m_prev = 0; m_armed = 0;
    m_busy = 0; m_gap = 0; m_id = 0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      wr  = ($urandom_range(0, 5) == 0);
      rd  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = IEA;
        1, 2:    a = IFA;
        default: a = 16'($urandom);
      endcase
      din = 8'($urandom);
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) == 0)
          src_e[i] = em[i] ? ~src_e[i] : 1'b1;
        else if (!em[i])
          src_e[i] = 1'b0;
      end
      ack_e = ($urandom_range(0, 2) == 0);
      #1 model_cycle();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
